// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction ROM port, decode handshake and jump request.
interface fetch_unit_if #(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 3
);
  logic               rom_enable;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;

  // Fetch unit side
  modport master (
    output rom_enable, rom_addr, instr, instr_valid,
    input  rom_data, instr_ready, jump_en, jump_addr
  );

  // ROM / decode side
  modport slave (
    input  rom_enable, rom_addr, instr, instr_valid,
    output rom_data, instr_ready, jump_en, jump_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer in front of a 1-cycle registered ROM.
// Each instruction takes REQ -> CAPT -> VALID; the decode handshake in VALID
// selects the next pc (sequential, jump, or halt at program end).
module fetch_unit #(
  parameter int ADDR_W   = 3,
  parameter int INSTR_W  = 3,
  parameter int PROG_LEN = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  fetch_unit_if.master      bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    CAPT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W:0]   PROG_SIZE = (ADDR_W + 1)'(PROG_LEN);

  state_t             state, state_next;
  logic [ADDR_W-1:0]  pc_next;
  logic [INSTR_W-1:0] instr_q, instr_next;
  logic               valid_q, valid_next;
  logic               jump_in_range;

  // Jump target check done one bit wider so PROG_LEN == 2**ADDR_W still works
  assign jump_in_range = {1'b0, bus.jump_addr} < PROG_SIZE;

  // State, pc and captured instruction registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc      <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      instr_q <= instr_next;
      valid_q <= valid_next;
    end
  end

  // Next-state, next-pc and capture decisions
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr_q;
    valid_next = valid_q;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_next    = '0;
          state_next = REQ;
        end
      end
      REQ: state_next = CAPT;
      CAPT: begin
        instr_next = bus.rom_data;
        valid_next = 1'b1;
        state_next = VALID;
      end
      VALID: begin
        if (bus.instr_ready) begin
          valid_next = 1'b0;
          if (bus.jump_en) begin
            if (jump_in_range) begin
              pc_next    = bus.jump_addr;
              state_next = REQ;
            end else begin
              state_next = HALT;
            end
          end else if (pc == LAST_PC) begin
            state_next = HALT;
          end else begin
            pc_next    = pc + ADDR_W'(1);
            state_next = REQ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.rom_enable  = (state == REQ);
  assign bus.rom_addr    = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign halted          = (state == HALT);

endmodule
